// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch_unit                                             |
// | Description : PC owner, RAM fetch issue, prefetch FIFO and redirect flush. |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic              fetch_req,
    output logic [ADDR_W-1:0] fetch_address,
    input  logic [DATA_W-1:0] fetch_out,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0]   c_DEPTH = (c_CNT_W + 1)'(DEPTH);

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic                r_inflight;
    logic [ADDR_W-1:0]   r_inflight_pc;
    logic [DATA_W-1:0]   r_mem_instr [DEPTH];
    logic [ADDR_W-1:0]   r_mem_pc    [DEPTH];
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;

    logic                w_pop;
    logic                w_push;
    logic                w_fetch_req;
    logic [c_CNT_W:0]    w_occupancy;

    assign w_pop  = instr_valid & instr_ready & ~redirect_valid;
    assign w_push = r_inflight & ~redirect_valid;

    // Slots committed after this edge: stored + arriving - leaving.
    assign w_occupancy = {1'b0, r_count}
                       + {{c_CNT_W{1'b0}}, r_inflight}
                       - {{c_CNT_W{1'b0}}, w_pop};

    assign w_fetch_req = (r_state == RUN) & fetch_en & ~redirect_valid
                       & (w_occupancy < c_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_instr[i] <= '0;
                r_mem_pc[i]    <= '0;
            end
        end else begin
            if (r_state == BOOT && fetch_en) begin
                r_state <= RUN;
            end
            if (redirect_valid) begin
                r_pc       <= redirect_pc;
                r_inflight <= 1'b0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
            end else begin
                r_inflight <= w_fetch_req;
                if (w_fetch_req) begin
                    r_pc          <= r_pc + 1'b1;
                    r_inflight_pc <= r_pc;
                end
                if (w_push) begin
                    r_mem_instr[r_wr_ptr] <= fetch_out;
                    r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
                    r_wr_ptr              <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign fetch_req     = w_fetch_req;
    assign fetch_address = r_pc;
    assign instr         = r_mem_instr[r_rd_ptr];
    assign instr_pc      = r_mem_pc[r_rd_ptr];
    assign instr_valid   = (r_count != '0);
    assign busy          = r_inflight | instr_valid;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_fetch_unit                                          |
// | Description : Scoreboard bench for instr_fetch_unit with a 1-cycle RAM.    |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;

    localparam int          ADDR_W   = 16;
    localparam int          DATA_W   = 32;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    logic              clk;
    logic              rst_n;
    logic              fetch_en;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_address;
    logic [DATA_W-1:0] fetch_out;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              busy;

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .fetch_req      (fetch_req),
        .fetch_address  (fetch_address),
        .fetch_out      (fetch_out),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_pops   = 0;
    logic [15:0] exp_q[$];
    logic [15:0] req_addrs[$];
    logic        req_seen = 1'b0;
    logic [15:0] req_addr_l = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] ram_word(input logic [15:0] a);
        return 32'hA000_0000 + {16'h0000, a};
    endfunction

    // Expected delivery order: a straight sequential run from the latest restart point.
    task automatic fill(input logic [15:0] start);
        logic [15:0] v;
        exp_q.delete();
        for (int i = 0; i < 1024; i++) begin
            v = start + 16'(i);
            exp_q.push_back(v);
        end
    endtask

    // RAM fetch port: read latency of one cycle, random garbage otherwise.
    always @(negedge clk) begin
        req_seen   <= rst_n && fetch_req;
        req_addr_l <= fetch_address;
        if (rst_n && fetch_req) req_addrs.push_back(fetch_address);
    end
    always @(posedge clk) fetch_out <= req_seen ? ram_word(req_addr_l) : $urandom;

    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_valid && instr_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_instr: got pc %h expected none", instr_pc);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    chk("instr_pc", 32'(instr_pc), 32'(e));
                    chk("instr", instr, ram_word(e));
                    n_pops++;
                end
            end
            if (dut.r_inflight && !redirect_valid)
                chk("push_not_full", 32'(dut.r_count != DEPTH), 32'd1);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_fetch_req", 32'(fetch_req), 32'd0);
        chk("rst_fetch_address", 32'(fetch_address), 32'(RESET_PC));
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", 32'(instr_pc), 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
    endtask

    task automatic do_reset(input logic rdy);
        rst_n          = 1'b0;
        fetch_en       = 1'b1;
        instr_ready    = rdy;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        fill(RESET_PC);
        req_addrs.delete();
        repeat (2) step();
        check_reset_vals();
        rst_n = 1'b1;
    endtask

    // Called right after the BOOT edge; request in cycle 1, valid in cycle 3.
    task automatic wait_first_valid();
        int n;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk("first_req", 32'(fetch_req), 32'd1);
                chk("first_addr", 32'(fetch_address), 32'(RESET_PC));
            end
            if (instr_valid) begin
                n = k;
                break;
            end
        end
        chk("first_valid_cycle", 32'(n), 32'd3);
    endtask

    initial begin
        int found;
        int pops0;
        rst_n = 1'b0;

        // Sequential stream with no gaps
        do_reset(1'b1);
        step();
        wait_first_valid();
        for (int i = 0; i < 20; i++) begin
            step();
            @(negedge clk);
            chk("no_gap", 32'(instr_valid), 32'd1);
        end

        // Backpressure from the start
        do_reset(1'b0);
        step();
        repeat (10) step();
        chk("bp_req_count", 32'(req_addrs.size()), 32'd4);
        for (int i = 0; i < req_addrs.size() && i < 4; i++)
            chk("bp_req_addr", 32'(req_addrs[i]), 32'(i));
        chk("bp_fetch_req", 32'(fetch_req), 32'd0);
        chk("bp_count", 32'(dut.r_count), 32'd4);
        instr_ready = 1'b1;
        repeat (10) step();

        // Redirect with three stored and one in flight
        do_reset(1'b0);
        step();
        found = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (dut.r_count == 3 && dut.r_inflight) begin
                found = 1;
                break;
            end
        end
        chk("rd_setup", 32'(found), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 16'h0040;
        instr_ready    = 1'b1;
        fill(16'h0040);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd_req", 32'(fetch_req), 32'd1);
        chk("rd_addr", 32'(fetch_address), 32'h40);
        chk("rd_valid_r1", 32'(instr_valid), 32'd0);
        step();
        @(negedge clk);
        chk("rd_valid_r2", 32'(instr_valid), 32'd0);
        step();
        @(negedge clk);
        chk("rd_valid_r3", 32'(instr_valid), 32'd1);
        chk("rd_pc_r3", 32'(instr_pc), 32'h40);
        repeat (6) step();

        // Wrap across the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 16'hFFFE;
        fill(16'hFFFE);
        pops0 = n_pops;
        step();
        redirect_valid = 1'b0;
        repeat (8) step();
        chk("wrap_pops", 32'(n_pops - pops0 >= 4), 32'd1);

        // Halt for five cycles mid-stream
        fetch_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("halt_no_req", 32'(fetch_req), 32'd0);
            step();
        end
        fetch_en = 1'b1;
        repeat (10) step();

        // Asynchronous reset pulse between edges
        step();
        #1;
        rst_n = 1'b0;
        fill(RESET_PC);
        req_addrs.delete();
        #1;
        check_reset_vals();
        #1;
        rst_n = 1'b1;
        step();
        wait_first_valid();
        repeat (10) step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step();
            fetch_en    = ($urandom % 8) != 0;
            instr_ready = ($urandom % 3) != 0;
            if ($urandom % 25 == 0) begin
                redirect_valid = 1'b1;
                redirect_pc    = 16'($urandom);
                fill(redirect_pc);
            end else begin
                redirect_valid = 1'b0;
            end
        end

        // Drain to idle
        step();
        redirect_valid = 1'b0;
        fetch_en       = 1'b0;
        instr_ready    = 1'b1;
        repeat (8) step();
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_valid", 32'(instr_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end stage of the 32-bit processor, directly upstream of the system wiring/decode stage. It owns the program counter, issues word reads on the RAM fetch port, buffers returned words in a small prefetch FIFO, and presents them as `instr` with a valid/ready handshake. A one-cycle redirect (branch or jump) flushes the buffer, discards in-flight data and restarts fetch at a new address.

## Interface
- `ADDR_W`, 16, width of `fetch_address` and all PC values (word address)
- `DATA_W`, 32, instruction width
- `DEPTH`, 4, prefetch FIFO entries (power of two, ≥2)
- `RESET_PC`, 16'h0000, first fetch address after reset

- `clk`  in  1  single clock; all state changes on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `fetch_en`  in  1  1 = new fetches allowed; 0 = hold (halt)
- `fetch_req`  out  1  read request to the RAM fetch port this cycle
- `fetch_address`  out  ADDR_W  word address for `fetch_req`
- `fetch_out`  in  DATA_W  RAM fetch data, valid the cycle after an accepted request
- `instr`  out  DATA_W  FIFO head instruction
- `instr_pc`  out  ADDR_W  address `instr` was fetched from
- `instr_valid`  out  1  FIFO non-empty
- `instr_ready`  in  1  downstream accepts head this cycle
- `redirect_valid`  in  1  one-cycle redirect strobe
- `redirect_pc`  in  ADDR_W  new fetch address
- `busy`  out  1  request in flight or FIFO non-empty

## Operation
- States: BOOT, RUN. Reset → BOOT. BOOT → RUN on first rising edge with `rst_n`=1 and `fetch_en`=1. RUN has no exit except reset.
- Registers: `pc`, `inflight` (1 bit), `inflight_pc`, FIFO (`DEPTH` × {instr, pc}), read/write pointers, `count` (0..DEPTH).
- pop = `instr_valid` & `instr_ready` & !`redirect_valid`.
- `fetch_req` (combinational) = RUN & `fetch_en` & !`redirect_valid` & (`count` + `inflight` − pop < DEPTH).
- `fetch_address` = `pc`. On an issued request: `pc` ← `pc`+1 modulo 2^ADDR_W (16'hFFFF → 16'h0000), `inflight` ← 1, `inflight_pc` ← `pc`; otherwise `inflight` ← 0.
- push = `inflight` & !`redirect_valid`: write {`fetch_out`, `inflight_pc`} at tail.
- Push and pop in the same cycle: `count` unchanged, both pointers advance. Push never occurs when `count`=DEPTH (guaranteed by the issue rule; verification asserts it).
- Redirect (`redirect_valid`=1, any state of FIFO): at that edge FIFO cleared (`count`←0, pointers←0), `pc` ← `redirect_pc`, `inflight` ← 0, word arriving that cycle dropped, pop ignored, no request issued. Fetch from `redirect_pc` issues the following cycle. Redirect in BOOT only loads `pc`.
- `fetch_en`=0: no new requests; in-flight word still pushed; FIFO still drains.
- `instr`/`instr_pc` = FIFO head from registers; hold last head value when empty (content don't-care, `instr_valid`=0).
- `busy` = `inflight` | (`count`≠0).

## Timing
- Reset values: `pc`=RESET_PC, `fetch_req`=0, `fetch_address`=RESET_PC, `instr`=0, `instr_pc`=0, `instr_valid`=0, `busy`=0, `count`=0, `inflight`=0, state BOOT. Asserting `rst_n` low mid-fetch clears everything immediately, with no wait for the edge.
- RAM latency fixed at 1: request at cycle t, data in `fetch_out` during t+1, captured at end of t+1, `instr_valid` high in t+2.
- Reset to first `instr_valid`: BOOT edge, request in cycle 1, data in cycle 2, valid in cycle 3.
- Sustained throughput 1 instr/cycle with `instr_ready` held high.
- Redirect latency: strobe in cycle r → request for `redirect_pc` in r+1 → `instr_valid` with `instr_pc`=`redirect_pc` in r+3.
- Backpressure: `instr_ready`=0 indefinitely → at most DEPTH entries stored, `fetch_req` stays 0 once `count`+`inflight`=DEPTH.

## Test plan
- Reset, `fetch_en`=1, `instr_ready`=1, RAM[i]=32'hA000_0000+i → `instr_valid` first in cycle 3 with `instr`=32'hA000_0000, `instr_pc`=0, then one instr per cycle with pc 1,2,3… and no gaps.
- `instr_ready`=0 from start → exactly 4 requests issued (addresses 0–3), `count`=4, `fetch_req`=0; release ready → words 0..3 drain in order, fetching resumes at 4.
- Redirect to 16'h0040 while FIFO holds 3 entries and one is in flight → all 4 dropped, next `instr_pc`=16'h0040 appears 3 cycles after the strobe, no word from old stream ever delivered.
- `redirect_pc`=16'hFFFE → delivered pcs FFFE, FFFF, 0000, 0001 (wrap).
- `fetch_en` dropped for 5 cycles mid-stream → in-flight word still delivered, no `fetch_req` for those cycles, stream resumes at the next sequential pc with no duplicate or skip.
- `rst_n` pulsed low mid-stream between edges → all outputs reach reset values immediately; restart fetches from RESET_PC.
